note_lane_judge: RTL
====================

NOTE_LANE_JUDGE -- requirements
Module: note_lane_judge

Interface
REQ-001 Parameter PERFECT_WIN, default 3, maximum |frame - note time| (frames) for a PERFECT judgement.
REQ-002 Parameter GOOD_WIN, default 6, maximum |frame - note time| (frames) for a GOOD judgement; GOOD_WIN > PERFECT_WIN.
REQ-003 Clk  input  1  system clock; single clock domain.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins chart playback.
REQ-006 frame_tick  input  1  one-cycle pulse per 1/60 s video frame.
REQ-007 key_pressed  input  1  level, lane key held (already synchronised).
REQ-008 key_1  input  16  head chart entry at addr: [15:14] type (00 tap, 01 hold start, 10 hold end), [13:0] timestamp in frames.
REQ-009 addr  output  8  chart ROM read address of the head entry.
REQ-010 judge_valid  output  1  one-cycle pulse when a judgement is issued.
REQ-011 judge_code  output  2  00 none, 01 PERFECT, 10 GOOD, 11 MISS; held until the next judgement.
REQ-012 combo  output  10  current consecutive-hit count.
REQ-013 score  output  16  accumulated score.
REQ-014 done  output  1  high while the chart is finished.

Function
REQ-015 The block SHALL implement states IDLE, PLAY, HOLD, DONE; start in IDLE -> PLAY; start in any other state is ignored.
REQ-016 A 14-bit frame counter SHALL clear on entering PLAY from IDLE, increment on frame_tick in PLAY/HOLD, and saturate at 16383.
REQ-017 A press SHALL be the rising edge of key_pressed (registered previous value); the edge register clears on reset.
REQ-018 PLAY, head type 00/01: press with |frame - ts| <= PERFECT_WIN -> PERFECT; <= GOOD_WIN -> GOOD; otherwise ignored, no penalty.
REQ-019 PLAY: frame > ts + GOOD_WIN with no qualifying press -> MISS; a qualifying press in the same cycle takes priority.
REQ-020 Judgement outputs and addr advance SHALL be registered: one cycle after the deciding condition, judge_valid pulses and addr updates together.
REQ-021 Tap judged -> addr+1; hold start hit -> addr+1, enter HOLD; hold start MISS -> addr+2 (skip its end entry), stay PLAY.
REQ-022 HOLD (head is type 10, time te): key held at frame >= te -> PERFECT; release in [te-GOOD_WIN, te) -> GOOD; release before te-GOOD_WIN -> MISS; all advance addr+1 and return to PLAY.
REQ-023 Head entry of type 10 in PLAY (orphan end) SHALL be skipped, addr+1, no judgement.
REQ-024 Timestamp differences SHALL be computed in 15-bit signed arithmetic; no wrap-around of the comparison.
REQ-025 PERFECT: score +2, combo +1; GOOD: score +1, combo +1; MISS: combo cleared; score and combo saturate at all-ones.
REQ-026 key_1 == 16'h0000 with addr != 0, or an advance that would pass addr 255, SHALL enter DONE without wrapping addr; done = 1 in DONE only.
REQ-027 DONE is left only by Reset.

Reset
REQ-028 Reset SHALL, at any time including mid-hold, force IDLE, addr 0, frame counter 0, judge_valid 0, judge_code 00, combo 0, score 0, done 0.

Configuration
REQ-029 With NOTE_AUTOPLAY_EN defined, key_pressed SHALL be ignored and every tap/hold-start/hold-end is judged PERFECT in the cycle after frame == ts; without it, judgement uses key_pressed per REQ-018..022.

Structure
REQ-030 Package note_pkg SHALL hold the judge_code enum, note type constants (TAP, HOLD_S, HOLD_E), state enum, and score increments.
REQ-031 Sub-module note_window_cmp (combinational: frame, ts, windows -> in_perfect, in_good, late) SHALL be instantiated once.

Verification
REQ-032 key_1=16'h0032 (tap @50), press at frame 52 -> PERFECT, score 2, combo 1, addr 0->1.
REQ-033 key_1=16'h0032, press at frame 55 -> GOOD, score 1; no press -> MISS in cycle after frame 57, combo 0.
REQ-034 key_1=16'h4100 (hold @256) then 16'h8110 (end @272): press 256, hold past 272 -> two PERFECTs, addr 0->2, state PLAY.
REQ-035 Same hold, release at frame 262 -> PERFECT then MISS; no press at all -> one MISS, addr 0->2.
REQ-036 Reset asserted in HOLD at frame 300 -> next cycle IDLE, addr 0, score 0; key_1=16'h0000 at addr 5 -> done=1.
REQ-037 NOTE_AUTOPLAY_EN defined, key_pressed=0, tap @50 -> PERFECT issued cycle after frame 50.

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and constants for the single-lane rhythm-game note judge.
package note_pkg;

    typedef enum logic [1:0] {
        JC_NONE    = 2'b00,
        JC_PERFECT = 2'b01,
        JC_GOOD    = 2'b10,
        JC_MISS    = 2'b11
    } judge_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam logic [1:0]  TAP    = 2'b00;
    localparam logic [1:0]  HOLD_S = 2'b01;
    localparam logic [1:0]  HOLD_E = 2'b10;

    localparam logic [15:0] SCORE_PERFECT = 16'd2;
    localparam logic [15:0] SCORE_GOOD    = 16'd1;
    localparam logic [13:0] FRAME_MAX     = 14'h3fff;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hffff : s[15:0];
    endfunction

endpackage

// File: rtl/note_window_cmp.sv
// Combinational timing-window test of the current frame against a note timestamp.
// Signed 15-bit difference, so an early frame never wraps into a "late" result.
module note_window_cmp #(
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 6
) (
    input  logic [13:0] frame,
    input  logic [13:0] ts,
    output logic        in_perfect,
    output logic        in_good,
    output logic        late,
    output logic        early
);

    localparam logic signed [14:0] PW = 15'(PERFECT_WIN);
    localparam logic signed [14:0] GW = 15'(GOOD_WIN);

    logic signed [14:0] diff;
    logic signed [14:0] mag;

    assign diff       = $signed({1'b0, frame}) - $signed({1'b0, ts});
    assign mag        = diff[14] ? -diff : diff;
    assign in_perfect = (mag <= PW);
    assign in_good    = (mag <= GW);
    assign late       = (diff > GW);
    assign early      = diff[14];

endmodule

// File: rtl/note_lane_judge.sv
// One-lane note judge: walks the chart ROM, grades presses/holds, tracks combo and score.
// Build option NOTE_AUTOPLAY_EN: ignore the key and judge every note PERFECT on time.
module note_lane_judge
    import note_pkg::*;
#(
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        key_pressed,
    input  logic [15:0] key_1,
    output logic [7:0]  addr,
    output logic        judge_valid,
    output logic [1:0]  judge_code,
    output logic [9:0]  combo,
    output logic [15:0] score,
    output logic        done
);

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [13:0] frame_q, frame_d;
    logic        key_q;
    logic        vld_q, vld_d;
    judge_code_e code_q, code_d;
    logic [9:0]  combo_q, combo_d;
    logic [15:0] score_q, score_d;

    logic [1:0]  head_type;
    logic [13:0] head_ts;
    logic        press;
    logic        in_perfect, in_good, late, early;
    logic        hit_perfect, hit_good, end_perfect, end_release;
    logic        chart_end;
    judge_code_e verdict;
    logic [1:0]  step;
    logic        to_hold;

    assign head_type = key_1[15:14];
    assign head_ts   = key_1[13:0];
    assign press     = key_pressed & ~key_q;
    assign chart_end = (key_1 == 16'h0000) && (addr_q != 8'd0);

    note_window_cmp #(
        .PERFECT_WIN (PERFECT_WIN),
        .GOOD_WIN    (GOOD_WIN)
    ) u_cmp (
        .frame      (frame_q),
        .ts         (head_ts),
        .in_perfect (in_perfect),
        .in_good    (in_good),
        .late       (late),
        .early      (early)
    );

`ifdef NOTE_AUTOPLAY_EN
    assign hit_perfect = (head_ts == frame_q);
    assign hit_good    = 1'b0;
    assign end_perfect = ~early;
    assign end_release = 1'b0;
`else
    assign hit_perfect = press & in_perfect;
    assign hit_good    = press & in_good;
    assign end_perfect = ~early;
    assign end_release = ~key_pressed;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        frame_d = frame_q;
        vld_d   = 1'b0;
        code_d  = code_q;
        combo_d = combo_q;
        score_d = score_q;
        verdict = JC_NONE;
        step    = 2'd0;
        to_hold = 1'b0;

        if ((state_q == ST_PLAY || state_q == ST_HOLD) && frame_tick && frame_q != FRAME_MAX)
            frame_d = frame_q + 14'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    frame_d = '0;
                end
            end
            ST_PLAY: begin
                if (chart_end) begin
                    state_d = ST_DONE;
                end else if (head_type != TAP && head_type != HOLD_S) begin
                    step = 2'd1;
                end else if (hit_perfect) begin
                    verdict = JC_PERFECT;
                    step    = 2'd1;
                    to_hold = (head_type == HOLD_S);
                end else if (hit_good) begin
                    verdict = JC_GOOD;
                    step    = 2'd1;
                    to_hold = (head_type == HOLD_S);
                end else if (late) begin
                    // a missed hold start also drops its end entry
                    verdict = JC_MISS;
                    step    = (head_type == HOLD_S) ? 2'd2 : 2'd1;
                end
            end
            ST_HOLD: begin
                if (chart_end) begin
                    state_d = ST_DONE;
                end else if (end_perfect) begin
                    verdict = JC_PERFECT;
                    step    = 2'd1;
                    state_d = ST_PLAY;
                end else if (end_release) begin
                    verdict = in_good ? JC_GOOD : JC_MISS;
                    step    = 2'd1;
                    state_d = ST_PLAY;
                end
            end
            default: ;
        endcase

        if (step != 2'd0) begin
            if (({1'b0, addr_q} + {7'b0, step}) > 9'd255) begin
                state_d = ST_DONE;
            end else begin
                addr_d = addr_q + {6'b0, step};
                if (to_hold)
                    state_d = ST_HOLD;
            end
        end

        if (verdict != JC_NONE) begin
            vld_d  = 1'b1;
            code_d = verdict;
            if (verdict == JC_MISS) begin
                combo_d = '0;
            end else begin
                combo_d = (combo_q == 10'h3ff) ? combo_q : combo_q + 10'd1;
                score_d = sat_add16(score_q, (verdict == JC_PERFECT) ? SCORE_PERFECT : SCORE_GOOD);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            frame_q <= '0;
            key_q   <= 1'b0;
            vld_q   <= 1'b0;
            code_q  <= JC_NONE;
            combo_q <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            frame_q <= frame_d;
            key_q   <= key_pressed;
            vld_q   <= vld_d;
            code_q  <= code_d;
            combo_q <= combo_d;
            score_q <= score_d;
        end
    end

    assign addr        = addr_q;
    assign judge_valid = vld_q;
    assign judge_code  = code_q;
    assign combo       = combo_q;
    assign score       = score_q;
    assign done        = (state_q == ST_DONE);

endmodule
